// File: rtl/lv1a_pipeline_gen.sv
// lv1a pre-trigger pipeline: merges masked trigger lines into lv1a accepts,
// gates/inhibits/rejects them, emits the pre-lv1 pulse and, after a
// programmable delay, hands the buffered event data to the lv1b type block.
module lv1a_pipeline_gen #(
  parameter int N_INT  = 8,
  parameter int N_EXT  = 4,
  parameter int PIPE   = 512,
  parameter int DEPTH  = 16,
  parameter int ID_W   = 10,
  parameter int TS_W   = 32,
  parameter int PLV1_W = 3,
  localparam int DW    = $clog2(PIPE),
  localparam int TW    = N_INT + N_EXT + 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_live,
  input  logic [N_INT-1:0]  in_int_lv1a,
  input  logic [N_EXT-1:0]  in_ext_lv1a,
  input  logic              in_delta_lv1a,
  input  logic [N_INT-1:0]  int_mask,
  input  logic [N_EXT-1:0]  ext_mask,
  input  logic [7:0]        gate_len,
  input  logic [DW-1:0]     delay_lv1b_req,
  input  logic [TS_W-1:0]   in_timestamp,
  input  logic              in_lv1_inhibit,
  output logic              out_plv1,
  output logic              out_lv1b_req,
  output logic [ID_W-1:0]   out_event_id,
  output logic [TW-1:0]     out_trig_word,
  output logic [TS_W-1:0]   out_timestamp,
  output logic [31:0]       lv1a_cnt,
  output logic [31:0]       rej_gate_cnt,
  output logic [31:0]       rej_inh_cnt,
  output logic [31:0]       rej_full_cnt,
  output logic              underflow_err
);

  typedef struct packed {
    logic [TW-1:0]   trig;
    logic [TS_W-1:0] ts;
    logic [ID_W-1:0] id;
  } evt_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // counter slots: 0 accepts, 1 gate, 2 inhibit, 3 full
  logic [3:0][31:0] cnt_q, cnt_d;
  logic [PIPE-1:0]  vld_pipe_q, vld_pipe_d;
  logic [7:0]       gate_cnt_q, gate_cnt_d;
  logic [ID_W-1:0]  evt_id_q, evt_id_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      fcnt_q, fcnt_d;
  logic             live_q, plv1_q, plv1_d, req_q, req_d, uflow_q, uflow_d;
  evt_t             out_evt_q, out_evt_d;
  evt_t             mem [DEPTH];

  logic             rise, req, gate_blk, acc, rej_gate, rej_inh, rej_full;
  logic             tap, empty, bypass, pop, wr;
  logic [DW-1:0]    d_eff;
  logic [3:0]       inc;
  evt_t             push_evt, head;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
  endfunction

  // accept/reject decision, pipeline shift, FIFO bookkeeping and counters
  always_comb begin
    rise     = in_live & ~live_q;
    req      = in_live & ((|(in_int_lv1a & int_mask)) | (|(in_ext_lv1a & ext_mask)) | in_delta_lv1a);
    gate_blk = (gate_cnt_q != 8'd0);
    rej_gate = req & gate_blk;
    rej_inh  = req & ~gate_blk & in_lv1_inhibit;
    rej_full = req & ~gate_blk & ~in_lv1_inhibit & (fcnt_q == FULL_CNT);
    acc      = req & ~gate_blk & ~in_lv1_inhibit & (fcnt_q != FULL_CNT);
    inc      = {rej_full, rej_inh, rej_gate, acc};

    vld_pipe_d = in_live ? {vld_pipe_q[PIPE-2:0], acc} : '0;
    d_eff      = (delay_lv1b_req == '0) ? DW'(1) : delay_lv1b_req;
    tap        = vld_pipe_d[d_eff - 1'b1];

    push_evt = '{trig: {in_delta_lv1a, in_ext_lv1a, in_int_lv1a}, ts: in_timestamp, id: evt_id_q};
    empty    = (fcnt_q == '0);
    // delay of 1 with an empty FIFO: hand the pushing event straight through
    bypass   = tap & empty & acc;
    pop      = tap & ~empty;
    wr       = acc & ~bypass;
    head     = bypass ? push_evt : mem[rd_ptr_q];

    fcnt_d   = in_live ? fcnt_q + (AW+1)'(wr) - (AW+1)'(pop) : '0;
    wr_ptr_d = in_live ? wr_ptr_q + AW'(wr) : '0;
    rd_ptr_d = in_live ? rd_ptr_q + AW'(pop) : '0;
    evt_id_d = in_live ? evt_id_q + ID_W'(acc) : '0;

    gate_cnt_d = gate_cnt_q;
    if (!in_live)               gate_cnt_d = '0;
    else if (acc)               gate_cnt_d = (gate_len == 8'd0) ? 8'd0 : gate_len - 8'd1;
    else if (gate_cnt_q != '0)  gate_cnt_d = gate_cnt_q - 8'd1;

    plv1_d    = in_live & (|vld_pipe_d[PLV1_W-1:0]);
    req_d     = pop | bypass;
    out_evt_d = (pop | bypass) ? head : out_evt_q;

    for (int i = 0; i < 4; i++)
      cnt_d[i] = sat_inc(rise ? 32'd0 : cnt_q[i], inc[i]);
    uflow_d = (rise ? 1'b0 : uflow_q) | (tap & empty & ~acc);
  end

  // state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      vld_pipe_q <= '0;
      gate_cnt_q <= '0;
      evt_id_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fcnt_q     <= '0;
      live_q     <= 1'b0;
      plv1_q     <= 1'b0;
      req_q      <= 1'b0;
      uflow_q    <= 1'b0;
      out_evt_q  <= '0;
    end else begin
      cnt_q      <= cnt_d;
      vld_pipe_q <= vld_pipe_d;
      gate_cnt_q <= gate_cnt_d;
      evt_id_q   <= evt_id_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fcnt_q     <= fcnt_d;
      live_q     <= in_live;
      plv1_q     <= plv1_d;
      req_q      <= req_d;
      uflow_q    <= uflow_d;
      out_evt_q  <= out_evt_d;
    end
  end

  // event storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr_q] <= push_evt;
  end

  assign out_plv1      = plv1_q;
  assign out_lv1b_req  = req_q;
  assign out_event_id  = out_evt_q.id;
  assign out_trig_word = out_evt_q.trig;
  assign out_timestamp = out_evt_q.ts;
  assign lv1a_cnt      = cnt_q[0];
  assign rej_gate_cnt  = cnt_q[1];
  assign rej_inh_cnt   = cnt_q[2];
  assign rej_full_cnt  = cnt_q[3];
  assign underflow_err = uflow_q;

endmodule

// File: tb/tb_lv1a_pipeline_gen.sv
// Directed bench for lv1a_pipeline_gen: accept timing, gate/inhibit/full
// rejects, masks, delay edge cases, underflow, live toggle and async reset.
module tb_lv1a_pipeline_gen;

  logic        clk = 1'b0, rst = 1'b1, in_live = 1'b0;
  logic [7:0]  in_int_lv1a = '0, int_mask = 8'hFF, gate_len = '0;
  logic [3:0]  in_ext_lv1a = '0, ext_mask = 4'hF;
  logic        in_delta_lv1a = 1'b0, in_lv1_inhibit = 1'b0;
  logic [8:0]  delay_lv1b_req = 9'd40;
  logic [31:0] in_timestamp = '0;
  logic        out_plv1, out_lv1b_req, underflow_err;
  logic [9:0]  out_event_id;
  logic [12:0] out_trig_word;
  logic [31:0] out_timestamp, lv1a_cnt, rej_gate_cnt, rej_inh_cnt, rej_full_cnt;

  int n_chk = 0, n_fail = 0, cyc = 0, t0 = 0;

  typedef struct { int c; logic [9:0] id; logic [12:0] tw; logic [31:0] ts; } rec_t;
  rec_t mq[$];

  lv1a_pipeline_gen dut (
    .clk(clk), .rst(rst), .in_live(in_live),
    .in_int_lv1a(in_int_lv1a), .in_ext_lv1a(in_ext_lv1a), .in_delta_lv1a(in_delta_lv1a),
    .int_mask(int_mask), .ext_mask(ext_mask), .gate_len(gate_len),
    .delay_lv1b_req(delay_lv1b_req), .in_timestamp(in_timestamp),
    .in_lv1_inhibit(in_lv1_inhibit), .out_plv1(out_plv1), .out_lv1b_req(out_lv1b_req),
    .out_event_id(out_event_id), .out_trig_word(out_trig_word), .out_timestamp(out_timestamp),
    .lv1a_cnt(lv1a_cnt), .rej_gate_cnt(rej_gate_cnt), .rej_inh_cnt(rej_inh_cnt),
    .rej_full_cnt(rej_full_cnt), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // log every lv1b request with the cycle it appeared in
  always @(negedge clk)
    if (out_lv1b_req) mq.push_back('{c: cyc, id: out_event_id, tw: out_trig_word, ts: out_timestamp});

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // one-cycle request in the current cycle
  task automatic pulse(input logic [7:0] i, input logic [3:0] e, input logic d, input logic [31:0] ts);
    in_int_lv1a = i; in_ext_lv1a = e; in_delta_lv1a = d; in_timestamp = ts;
    tick(1);
    in_int_lv1a = '0; in_ext_lv1a = '0; in_delta_lv1a = 1'b0;
  endtask

  task automatic relive();
    in_live = 1'b0;
    tick(3);
    in_live = 1'b1;
    tick(1);
  endtask

  initial begin
    tick(3);
    chk("rst_plv1", out_plv1, 0);
    chk("rst_req", out_lv1b_req, 0);
    chk("rst_cnt", lv1a_cnt, 0);
    chk("rst_id", out_event_id, 0);
    chk("rst_uflow", underflow_err, 0);
    rst = 1'b0; in_live = 1'b1;
    tick(2);

    // single accept, plv1 window, lv1b at T+40
    t0 = cyc;
    pulse(8'h04, 4'h0, 1'b0, 32'h1234_5678);
    chk("t1_plv1_a", out_plv1, 1); tick(1);
    chk("t1_plv1_b", out_plv1, 1); tick(1);
    chk("t1_plv1_c", out_plv1, 1); tick(1);
    chk("t1_plv1_off", out_plv1, 0);
    chk("t1_cnt", lv1a_cnt, 1);
    tick(40);
    chk("t1_nreq", mq.size(), 1);
    if (mq.size() == 1) begin
      chk("t1_cyc", mq[0].c, t0 + 40);
      chk("t1_id", mq[0].id, 0);
      chk("t1_tw", mq[0].tw, 13'h004);
      chk("t1_ts", mq[0].ts, 32'h1234_5678);
    end
    chk("t1_req_low", out_lv1b_req, 0);
    chk("t1_ts_hold", out_timestamp, 32'h1234_5678);
    mq.delete();

    // gate of 20: requests at 0, 10, 20
    relive();
    gate_len = 8'd20;
    t0 = cyc;
    pulse(8'h01, 4'h0, 1'b0, 32'd100); tick(9);
    pulse(8'h02, 4'h0, 1'b0, 32'd200); tick(9);
    pulse(8'h04, 4'h0, 1'b0, 32'd300);
    chk("t2_acc", lv1a_cnt, 2);
    chk("t2_gate", rej_gate_cnt, 1);
    tick(45);
    chk("t2_nreq", mq.size(), 2);
    if (mq.size() == 2) begin
      chk("t2_c0", mq[0].c, t0 + 40);
      chk("t2_id0", mq[0].id, 0);
      chk("t2_tw0", mq[0].tw, 13'h001);
      chk("t2_c1", mq[1].c, t0 + 60);
      chk("t2_id1", mq[1].id, 1);
      chk("t2_ts1", mq[1].ts, 32'd300);
    end
    mq.delete();

    // gate outranks inhibit; inhibit alone counted outside gate
    pulse(8'h01, 4'h0, 1'b0, 32'd400); tick(4);
    in_lv1_inhibit = 1'b1;
    pulse(8'h01, 4'h0, 1'b0, 32'd0);
    chk("t3_gate", rej_gate_cnt, 2);
    chk("t3_inh0", rej_inh_cnt, 0);
    tick(19);
    pulse(8'h01, 4'h0, 1'b0, 32'd0);
    in_lv1_inhibit = 1'b0;
    chk("t3_inh1", rej_inh_cnt, 1);
    chk("t3_acc", lv1a_cnt, 3);
    tick(20);
    chk("t3_nreq", mq.size(), 1);
    if (mq.size() == 1) chk("t3_id", mq[0].id, 2);
    mq.delete();
    gate_len = 8'd0;

    // delay lengthened after the pop: tap fires again on an empty FIFO
    delay_lv1b_req = 9'd10;
    pulse(8'h01, 4'h0, 1'b0, 32'd0);
    tick(11);
    chk("t4_nreq_a", mq.size(), 1);
    delay_lv1b_req = 9'd30;
    tick(25);
    chk("t4_uflow", underflow_err, 1);
    chk("t4_nreq_b", mq.size(), 1);
    mq.delete();

    // FIFO full: 20 back-to-back requests, 16 fit
    relive();
    chk("t5_uflow_clr", underflow_err, 0);
    chk("t5_cnt_clr", lv1a_cnt, 0);
    delay_lv1b_req = 9'd200;
    t0 = cyc;
    for (int i = 0; i < 20; i++) begin
      in_int_lv1a = 8'h01; in_timestamp = 32'd1000 + 32'(i);
      tick(1);
    end
    in_int_lv1a = '0;
    chk("t5_acc", lv1a_cnt, 16);
    chk("t5_full", rej_full_cnt, 4);
    chk("t5_gate", rej_gate_cnt, 0);
    tick(200);
    chk("t5_nreq", mq.size(), 16);
    if (mq.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        chk($sformatf("t5_c%0d", i), mq[i].c, t0 + 200 + i);
        chk($sformatf("t5_id%0d", i), mq[i].id, i);
      end
      chk("t5_ts15", mq[15].ts, 32'd1015);
    end
    mq.delete();

    // masking; delta is never masked; trig word is raw
    relive();
    delay_lv1b_req = 9'd5;
    int_mask = 8'hFB; ext_mask = 4'h0;
    pulse(8'h04, 4'hF, 1'b0, 32'd0);
    chk("t6_mask_plv1", out_plv1, 0);
    tick(2);
    chk("t6_mask_cnt", lv1a_cnt, 0);
    chk("t6_mask_rej", rej_gate_cnt + rej_inh_cnt + rej_full_cnt, 0);
    int_mask = 8'h00;
    t0 = cyc;
    pulse(8'h04, 4'h3, 1'b1, 32'd777);
    chk("t6_delta_plv1", out_plv1, 1);
    chk("t6_delta_cnt", lv1a_cnt, 1);
    tick(6);
    chk("t6_nreq", mq.size(), 1);
    if (mq.size() == 1) begin
      chk("t6_c", mq[0].c, t0 + 5);
      chk("t6_tw", mq[0].tw, 13'h1304);
      chk("t6_ts", mq[0].ts, 32'd777);
    end
    // delay 0 behaves as 1, passing through an empty FIFO
    delay_lv1b_req = 9'd0;
    t0 = cyc;
    pulse(8'h00, 4'h0, 1'b1, 32'd888);
    tick(1);
    chk("t6_d0_nreq", mq.size(), 2);
    if (mq.size() == 2) begin
      chk("t6_d0_c", mq[1].c, t0 + 1);
      chk("t6_d0_id", mq[1].id, 1);
      chk("t6_d0_ts", mq[1].ts, 32'd888);
    end
    chk("t6_d0_uflow", underflow_err, 0);
    mq.delete();
    int_mask = 8'hFF; ext_mask = 4'hF;

    // live drop aborts in-flight event; rise clears counters; id restarts
    delay_lv1b_req = 9'd40;
    pulse(8'h01, 4'h0, 1'b0, 32'd0);
    tick(5);
    in_live = 1'b0;
    tick(3);
    chk("t7_hold_cnt", lv1a_cnt, 3);
    chk("t7_plv1_low", out_plv1, 0);
    in_live = 1'b1;
    tick(1);
    chk("t7_clr_cnt", lv1a_cnt, 0);
    tick(45);
    chk("t7_no_req", mq.size(), 0);
    delay_lv1b_req = 9'd3;
    t0 = cyc;
    pulse(8'h01, 4'h0, 1'b0, 32'd55);
    tick(4);
    chk("t7_nreq", mq.size(), 1);
    if (mq.size() == 1) begin
      chk("t7_id", mq[0].id, 0);
      chk("t7_c", mq[0].c, t0 + 3);
    end
    mq.delete();

    // async reset mid-pulse
    pulse(8'h01, 4'h0, 1'b0, 32'd0);
    chk("t8_plv1_pre", out_plv1, 1);
    #2 rst = 1'b1;
    #1;
    chk("t8_plv1_rst", out_plv1, 0);
    chk("t8_cnt_rst", lv1a_cnt, 0);
    chk("t8_id_rst", out_event_id, 0);
    tick(1);
    rst = 1'b0;
    tick(6);
    chk("t8_no_req", mq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
